// File: rtl/uart_router_ni.sv
// uart_router_ni
//   Host-to-network interface. Receives 4-byte UART frames (8N1, LSB first)
//   on TXD, validates them and injects each frame into the router as a head
//   flit followed by a tail flit on a 16-bit req/bussy handshake.
//   Frame layout: byte0 -> word[31:24] ... byte3 -> word[7:0].
//   head = {byte0, seq[class]}, tail = {byte2, byte3}, class = byte0[5].
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   TXD        in   UART line from host, idle high, asynchronous to clk
//   data       out  16-bit flit to router
//   req        out  flit valid
//   bussy      in   router stall; flit accepted when req=1 and bussy=0
//   frame_err  out  1-cycle pulse: bad stop bit or invalid type field
//   overflow   out  1-cycle pulse: frame completed while holding reg busy
module uart_router_ni #(
    parameter int unsigned BIT_CLKS     = 16,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        TXD,
    output logic [15:0] data,
    output logic        req,
    input  logic        bussy,
    output logic        frame_err,
    output logic        overflow
);

    localparam int unsigned HALF    = BIT_CLKS / 2;
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * BIT_CLKS;
    localparam int unsigned CW      = $clog2(BIT_CLKS);
    localparam int unsigned TW      = $clog2(TO_CLKS + 1);

    // R_BREAK waits for the line to return high after a bad stop bit
    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_HEAD,
        F_TAIL
    } fl_state_t;

    // ------------------------------------------------------------------
    // Receive side state
    // ------------------------------------------------------------------
    logic            txd_s1_q, txd_s2_q, txd_prev_q;
    rx_state_t       rx_state_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [1:0]      byte_idx_q;
    logic [7:0]      byte0_q;
    logic [7:0]      byte2_q;
    logic [TW-1:0]   idle_cnt_q;

    // ------------------------------------------------------------------
    // Flit side state
    // ------------------------------------------------------------------
    fl_state_t       fl_state_q;
    logic [15:0]     data_q;
    logic            req_q;
    logic [15:0]     tail_q;
    logic            cls_q;
    logic [7:0]      seq_reg_q;
    logic [7:0]      seq_pri_q;
    logic            frame_err_q;
    logic            overflow_q;

    // ------------------------------------------------------------------
    // Frame-level decisions, all evaluated in the byte3 stop-sample cycle
    // ------------------------------------------------------------------
    logic        stop_tick;
    logic        stop_good;
    logic        stop_bad;
    logic        frame_done;
    logic        type_ok;
    logic        accept;
    logic        hold_free;
    logic        load;
    logic [15:0] head_d;
    logic [15:0] tail_d;
    logic        frame_err_d;
    logic        overflow_d;

    always_comb begin
        stop_tick   = (rx_state_q == R_STOP) && (bit_cnt_q == CW'(BIT_CLKS - 1));
        stop_good   = stop_tick && txd_s2_q;
        stop_bad    = stop_tick && !txd_s2_q;
        frame_done  = stop_good && (byte_idx_q == 2'd3);
        // regular (000) or priority (001) in byte0, 110 in byte2
        type_ok     = (byte0_q[7:6] == 2'b00) && (byte2_q[7:5] == 3'b110);
        accept      = req_q && !bussy;
        // the tail leaving this cycle frees the holding reg for a new frame
        hold_free   = (fl_state_q == F_IDLE) || ((fl_state_q == F_TAIL) && accept);
        load        = frame_done && type_ok && hold_free;
        head_d      = {byte0_q, (byte0_q[5] ? seq_pri_q : seq_reg_q)};
        tail_d      = {byte2_q, shift_q};
        frame_err_d = stop_bad || (frame_done && !type_ok);
        overflow_d  = frame_done && type_ok && !hold_free;
    end

    // ------------------------------------------------------------------
    // Synchronizer and RX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_s1_q   <= 1'b1;
            txd_s2_q   <= 1'b1;
            txd_prev_q <= 1'b1;
            rx_state_q <= R_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            byte0_q    <= '0;
            byte2_q    <= '0;
            idle_cnt_q <= '0;
        end else begin
            txd_s1_q   <= TXD;
            txd_s2_q   <= txd_s1_q;
            txd_prev_q <= txd_s2_q;
            idle_cnt_q <= '0;

            case (rx_state_q)
                R_IDLE: begin
                    bit_cnt_q <= '0;
                    if (txd_prev_q && !txd_s2_q) begin
                        rx_state_q <= R_START;
                    end
                    // inter-byte timeout only matters with a partial frame
                    if (byte_idx_q != 2'd0) begin
                        if (idle_cnt_q == TW'(TO_CLKS - 1)) begin
                            byte_idx_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                end

                R_START: begin
                    if (bit_cnt_q == CW'(HALF - 1)) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        rx_state_q <= txd_s2_q ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                R_DATA: begin
                    if (bit_cnt_q == CW'(BIT_CLKS - 1)) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {txd_s2_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= R_STOP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                R_STOP: begin
                    if (stop_tick) begin
                        bit_cnt_q <= '0;
                        if (txd_s2_q) begin
                            if (byte_idx_q == 2'd0) begin
                                byte0_q <= shift_q;
                            end
                            if (byte_idx_q == 2'd2) begin
                                byte2_q <= shift_q;
                            end
                            // 3 -> 0 wrap ends the frame whatever its fate
                            byte_idx_q <= byte_idx_q + 2'd1;
                            rx_state_q <= R_IDLE;
                        end else begin
                            byte_idx_q <= '0;
                            rx_state_q <= R_BREAK;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                R_BREAK: begin
                    bit_cnt_q <= '0;
                    if (txd_s2_q) begin
                        rx_state_q <= R_IDLE;
                    end
                end

                default: begin
                    rx_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flit FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_state_q  <= F_IDLE;
            data_q      <= '0;
            req_q       <= 1'b0;
            tail_q      <= '0;
            cls_q       <= 1'b0;
            seq_reg_q   <= '0;
            seq_pri_q   <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;

            case (fl_state_q)
                F_IDLE: begin
                    if (load) begin
                        data_q     <= head_d;
                        tail_q     <= tail_d;
                        cls_q      <= byte0_q[5];
                        req_q      <= 1'b1;
                        fl_state_q <= F_HEAD;
                    end
                end

                F_HEAD: begin
                    if (accept) begin
                        data_q <= tail_q;
                        if (cls_q) begin
                            seq_pri_q <= seq_pri_q + 8'd1;
                        end else begin
                            seq_reg_q <= seq_reg_q + 8'd1;
                        end
                        fl_state_q <= F_TAIL;
                    end
                end

                F_TAIL: begin
                    if (accept) begin
                        if (load) begin
                            data_q     <= head_d;
                            tail_q     <= tail_d;
                            cls_q      <= byte0_q[5];
                            fl_state_q <= F_HEAD;
                        end else begin
                            req_q      <= 1'b0;
                            fl_state_q <= F_IDLE;
                        end
                    end
                end

                default: begin
                    req_q      <= 1'b0;
                    fl_state_q <= F_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign req       = req_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_router_ni.sv
module tb_uart_router_ni;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        txd, bussy;
    logic [15:0] data;
    logic        req, frame_err, overflow;

    logic        f_txd, f_bussy;
    logic [15:0] f_data;
    logic        f_req, f_err, f_ovf;

    // Main instance at 16 clks/bit; a fast instance at 4 clks/bit carries the
    // 257-frame sequence-wrap run so the bench stays short.
    uart_router_ni #(.BIT_CLKS(16), .TIMEOUT_BITS(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .TXD(txd), .data(data), .req(req),
        .bussy(bussy), .frame_err(frame_err), .overflow(overflow)
    );

    uart_router_ni #(.BIT_CLKS(4), .TIMEOUT_BITS(20)) u_fast (
        .clk(clk), .rst_n(rst_n), .TXD(f_txd), .data(f_data), .req(f_req),
        .bussy(f_bussy), .frame_err(f_err), .overflow(f_ovf)
    );

    int passed = 0;
    int total  = 0;

    logic [15:0] sq[$];
    logic [15:0] fq[$];
    int err_seen = 0, ovf_seen = 0, f_err_seen = 0, f_ovf_seen = 0;
    int exp_err = 0, exp_ovf = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever a flit is accepted
    always @(negedge clk) begin
        if (rst_n) begin
            if (req && !bussy) begin
                if (sq.size() == 0) begin
                    total++;
                    $display("FAIL slow_unexpected_flit: got %h expected none", data);
                end else begin
                    chk("slow_flit", int'(data), int'(sq.pop_front()));
                end
            end
            if (f_req && !f_bussy) begin
                if (fq.size() == 0) begin
                    total++;
                    $display("FAIL fast_unexpected_flit: got %h expected none", f_data);
                end else begin
                    chk("fast_flit", int'(f_data), int'(fq.pop_front()));
                end
            end
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (f_err)     f_err_seen++;
            if (f_ovf)     f_ovf_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_byte(input bit fast, input logic [7:0] b, input bit stop_ok);
        int          bc;
        logic [9:0]  fr;
        bc = fast ? 4 : 16;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (fast) f_txd = fr[i];
            else      txd   = fr[i];
            tick(bc);
        end
        if (fast) f_txd = 1'b1;
        else      txd   = 1'b1;
    endtask

    task automatic uart_frame(input bit fast, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        uart_byte(fast, b0, 1'b1);
        uart_byte(fast, b1, 1'b1);
        uart_byte(fast, b2, 1'b1);
        uart_byte(fast, b3, 1'b1);
        tick(fast ? 8 : 32);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && sq.size() != 0; k++) tick(1);
        tick(2);
        chk(name, sq.size(), 0);
        chk({name, "_err_cnt"}, err_seen, exp_err);
        chk({name, "_ovf_cnt"}, ovf_seen, exp_ovf);
    endtask

    task automatic slow_seq();
        int bad;
        int w;
        // 1: basic priority frame, then next priority frame gets seq 1
        sq.push_back(16'h2000); sq.push_back(16'hC53A);
        uart_frame(0, 8'h20, 8'h55, 8'hC5, 8'h3A);
        sq.push_back(16'h2001); sq.push_back(16'hC000);
        uart_frame(0, 8'h20, 8'h00, 8'hC0, 8'h00);
        drain("t1");

        // 3: head stalled 50+ clks, must hold
        bussy = 1'b1;
        sq.push_back(16'h0000); sq.push_back(16'hC001);
        uart_frame(0, 8'h00, 8'h11, 8'hC0, 8'h01);
        w = 0;
        while (!req && w < 400) begin tick(1); w++; end
        chk("t3_req_rise", int'(req), 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (!(req && data == 16'h0000)) bad++;
            tick(1);
        end
        chk("t3_stall_hold", bad, 0);
        bussy = 1'b0;
        drain("t3");

        // 4: second frame arrives while head still stalled -> overflow
        bussy = 1'b1;
        sq.push_back(16'h0001); sq.push_back(16'hC002);
        uart_frame(0, 8'h00, 8'h00, 8'hC0, 8'h02);
        exp_ovf++;
        uart_frame(0, 8'h00, 8'h00, 8'hC0, 8'h03);
        chk("t4_head_held", int'(data), 16'h0001);
        chk("t4_req_held", int'(req), 1);
        bussy = 1'b0;
        drain("t4");

        // 5a: invalid byte2 type field
        exp_err++;
        uart_frame(0, 8'h00, 8'h00, 8'h45, 8'h00);
        drain("t5a");

        // 5b: bad stop bit on byte1, then a clean frame
        uart_byte(0, 8'h00, 1'b1);
        uart_byte(0, 8'h00, 1'b0);
        exp_err++;
        tick(32);
        sq.push_back(16'h0002); sq.push_back(16'hC004);
        uart_frame(0, 8'h00, 8'h00, 8'hC0, 8'h04);
        drain("t5b");

        // 6a: 4-clk glitch must not start a byte
        txd = 1'b0; tick(4); txd = 1'b1; tick(40);
        sq.push_back(16'h2002); sq.push_back(16'hC005);
        uart_frame(0, 8'h20, 8'h00, 8'hC0, 8'h05);
        drain("t6a");

        // 6b: 21 bit-time gap after byte1 discards the partial frame
        uart_byte(0, 8'h00, 1'b1);
        uart_byte(0, 8'h00, 1'b1);
        tick(21 * 16);
        sq.push_back(16'h0003); sq.push_back(16'hC006);
        uart_frame(0, 8'h00, 8'h00, 8'hC0, 8'h06);
        drain("t6b");
    endtask

    task automatic fast_seq();
        // 2: regular sequence 00..FF then wrap to 00; priority untouched
        for (int i = 0; i < 257; i++) begin
            fq.push_back({8'h00, 8'(i)});
            fq.push_back(16'hC001);
            uart_frame(1, 8'h00, 8'(i), 8'hC0, 8'h01);
        end
        fq.push_back(16'h2000); fq.push_back(16'hC000);
        uart_frame(1, 8'h20, 8'h00, 8'hC0, 8'h00);
        for (int k = 0; k < 100 && fq.size() != 0; k++) tick(1);
        tick(2);
        chk("fast_drain", fq.size(), 0);
        chk("fast_err_cnt", f_err_seen, 0);
        chk("fast_ovf_cnt", f_ovf_seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        txd     = 1'b1;
        f_txd   = 1'b1;
        bussy   = 1'b0;
        f_bussy = 1'b0;
        tick(3);
        chk("rst_data", int'(data), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_fast_req", int'(f_req), 0);
        rst_n = 1'b1;
        tick(2);
        fork
            slow_seq();
            fast_seq();
        join
        tick(5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
